sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter DISP_W, default 64, logical display width in pixels.
REQ-002 Parameter DISP_H, default 32, logical display height in pixels.
REQ-003 Parameter SCALE, default 2, pixel replication factor (legal 1, 2, 4); physical framebuffer is (DISP_W*SCALE) x (DISP_H*SCALE) bits.
REQ-004 Parameter WRAP_MODE, default 0; 0 = clip off-screen pixels, 1 = wrap them modulo DISP_W/DISP_H.
REQ-005 Derived FB_AW = clog2(DISP_W*DISP_H*SCALE*SCALE/8), which is 10 at defaults.
REQ-006 clk_in  in  1  sole clock; reset is synchronous and active-high.
REQ-007 rst_in  in  1  synchronous active-high reset.
REQ-008 start  in  1  draw request, sampled only in IDLE.
REQ-009 x_in  in  8  logical X (raw Vx).
REQ-010 y_in  in  8  logical Y (raw Vy).
REQ-011 n_in  in  4  sprite row count.
REQ-012 spr_addr  in  12  sprite base address (I register).
REQ-013 mem_rd_addr  out  12  program memory read address, 1-cycle read latency.
REQ-014 mem_rd_data  in  8  program memory read data.
REQ-015 fb_addr  out  FB_AW  framebuffer byte address, shared for read and write.
REQ-016 fb_rd_data  in  8  framebuffer read data, 1-cycle latency.
REQ-017 fb_wr_data  out  8  framebuffer write data.
REQ-018 fb_wr_en  out  1  framebuffer write strobe.
REQ-019 busy  out  1  draw in progress.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 collision  out  1  VF result of the last draw.

Function
REQ-022 States SHALL be IDLE, FETCH, LATCH, PIX, FB_RD, FB_WR, DONE.
REQ-023 IDLE + start: latch x0 = x_in mod DISP_W, y0 = y_in mod DISP_H, n, spr_addr; clear collision, row and column counters; go to FETCH (or to DONE if n_in == 0).
REQ-024 FETCH: mem_rd_addr = spr_addr + row (12-bit wrap); go to LATCH.
REQ-025 LATCH: capture mem_rd_data as the row byte; col = 0; go to PIX.
REQ-026 PIX, one cycle per column, MSB = column 0: px = x0 + col, py = y0 + row; the pixel is drawn only if the bit is 1 and it is visible.
REQ-027 Visibility: WRAP_MODE=0 requires px < DISP_W and py < DISP_H; WRAP_MODE=1 subtracts DISP_W or DISP_H on overflow, so every pixel is visible.
REQ-028 A drawn pixel SHALL iterate sub-pixels (sx, sy) in sy-major order, each costing FB_RD then FB_WR, before the next column.
REQ-029 Physical bit index = (py*SCALE+sy)*(DISP_W*SCALE) + px*SCALE+sx; fb_addr = index>>3; bit position = 7-(index mod 8), MSB-first.
REQ-030 FB_RD: drive fb_addr; FB_WR: hold fb_addr, fb_wr_data = fb_rd_data XOR bit mask, fb_wr_en = 1 for exactly that cycle.
REQ-031 collision SHALL set if any sub-pixel read 1 before the XOR (sticky for the draw).
REQ-032 After column 7, increment row; if row == n go to DONE, else go to FETCH.
REQ-033 DONE: done = 1 and busy = 0 for one cycle, then IDLE; collision is held until the next accepted start.
REQ-034 busy = 1 in every state except IDLE and DONE.
REQ-035 Latency: busy cycles = 10*n + 2*SCALE*SCALE*(drawn pixel count); with n = 0, DONE follows start directly and collision = 0.
REQ-036 start while busy is ignored.
REQ-037 fb_wr_en SHALL be 0 in all states except FB_WR.
REQ-038 Each physical byte is read and written within two adjacent cycles; no write buffering.

Reset
REQ-039 rst_in on any cycle: state IDLE next cycle; busy, done, collision, fb_wr_en = 0; mem_rd_addr, fb_addr, fb_wr_data = 0.
REQ-040 Reset mid-draw: no fb_wr_en from the following cycle onward, and the partial image is left as-is.
REQ-041 Reset has priority over start in the same cycle.

Verification
REQ-042 Reset held 2 cycles -> all outputs 0; start asserted with reset -> busy stays 0.
REQ-043 Defaults, clear FB, sprite byte 0x80, n=1, x=0, y=0 -> writes 0xC0 to bytes 0 and 16 (two rows, two writes each); busy 18 cycles; done pulse; collision 0.
REQ-044 Repeat the REQ-043 draw -> bytes 0 and 16 return to 0x00; collision 1.
REQ-045 Sprite 0xC0, x=63, y=0, WRAP_MODE=0 -> bytes 15 and 31 = 0x03, byte 0 untouched; WRAP_MODE=1 -> bytes 0 and 16 additionally = 0xC0.
REQ-046 x_in=70, y_in=33, sprite 0x80 -> drawn at logical (6,1); start pulsed mid-draw -> no second draw.
REQ-047 rst_in asserted during FB_RD of the second pixel -> no further fb_wr_en; IDLE next cycle; a new start then completes normally.

Source files
------------

// File: rtl/sprite_blitter.sv
// XOR sprite blitter: draws 8-pixel-wide sprite rows into a 1bpp framebuffer
// with SCALE x SCALE pixel replication and collision detection.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | sprite row address on mem_rd_addr
// LATCH | capture sprite row byte
// PIX   | evaluate one column (bit + visibility)
// FB_RD | framebuffer byte address driven for read
// FB_WR | XOR write-back of the same byte
// DONE  | one-cycle completion pulse
module sprite_blitter #(
  parameter int DISP_W    = 64,
  parameter int DISP_H    = 32,
  parameter int SCALE     = 2,
  parameter int WRAP_MODE = 0,
  localparam int FB_AW    = $clog2(DISP_W * DISP_H * SCALE * SCALE / 8)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [7:0]       x_in,
  input  logic [7:0]       y_in,
  input  logic [3:0]       n_in,
  input  logic [11:0]      spr_addr,
  output logic [11:0]      mem_rd_addr,
  input  logic [7:0]       mem_rd_data,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_rd_data,
  output logic [7:0]       fb_wr_data,
  output logic             fb_wr_en,
  output logic             busy,
  output logic             done,
  output logic             collision
);

  localparam int IW = FB_AW + 3;

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PIX, FB_RD, FB_WR, DONE} state_t;

  state_t      state;
  logic [7:0]  x0, y0, row_byte, mask;
  logic [3:0]  n_q, row;
  logic [11:0] base;
  logic [2:0]  col;
  logic [1:0]  sx, sy;

  logic [31:0]   px, py;
  logic          visible, pix_on, last_sx, last_sy, last_col, last_row, row_end;
  logic [1:0]    nsx, nsy;
  logic [IW-1:0] idx0, idxn;

  function automatic logic [IW-1:0] bit_index(input logic [31:0] p_x, p_y,
                                              input logic [1:0] s_x, s_y);
    return IW'((p_y * SCALE + 32'(s_y)) * (DISP_W * SCALE) + p_x * SCALE + 32'(s_x));
  endfunction

  always_comb begin
    px      = 32'(x0) + 32'(col);
    py      = 32'(y0) + 32'(row);
    visible = 1'b1;
    if (px >= 32'(DISP_W)) begin
      if (WRAP_MODE == 1) px = px - 32'(DISP_W);
      else                visible = 1'b0;
    end
    if (py >= 32'(DISP_H)) begin
      if (WRAP_MODE == 1) py = py - 32'(DISP_H);
      else                visible = 1'b0;
    end
    pix_on   = row_byte[3'd7 - col] && visible;
    last_sx  = (sx == 2'(SCALE - 1));
    last_sy  = (sy == 2'(SCALE - 1));
    nsx      = last_sx ? 2'd0 : sx + 2'd1;
    nsy      = last_sx ? sy + 2'd1 : sy;
    last_col = (col == 3'd7);
    last_row = ((row + 4'd1) == n_q);
    idx0     = bit_index(px, py, 2'd0, 2'd0);
    idxn     = bit_index(px, py, nsx, nsy);
    row_end  = ((state == PIX) && !pix_on && last_col) ||
               ((state == FB_WR) && last_sx && last_sy && last_col);
  end

  // Write data is the read byte XORed in the write cycle itself (1-cycle read latency).
  assign fb_wr_data = fb_wr_en ? (fb_rd_data ^ mask) : 8'h00;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      x0          <= '0;
      y0          <= '0;
      n_q         <= '0;
      base        <= '0;
      row         <= '0;
      col         <= '0;
      sx          <= '0;
      sy          <= '0;
      row_byte    <= '0;
      mask        <= '0;
      mem_rd_addr <= '0;
      fb_addr     <= '0;
      fb_wr_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      collision   <= 1'b0;
    end else begin
      done     <= 1'b0;
      fb_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x0        <= 8'(32'(x_in) % DISP_W);
            y0        <= 8'(32'(y_in) % DISP_H);
            n_q       <= n_in;
            base      <= spr_addr;
            collision <= 1'b0;
            row       <= '0;
            col       <= '0;
            sx        <= '0;
            sy        <= '0;
            if (n_in == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FETCH;
              busy        <= 1'b1;
              mem_rd_addr <= spr_addr;
            end
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          row_byte <= mem_rd_data;
          col      <= '0;
          state    <= PIX;
        end
        PIX: begin
          if (pix_on) begin
            sx      <= '0;
            sy      <= '0;
            fb_addr <= idx0[IW-1:3];
            mask    <= 8'h80 >> idx0[2:0];
            state   <= FB_RD;
          end else if (!last_col) begin
            col <= col + 3'd1;
          end
        end
        FB_RD: begin
          fb_wr_en <= 1'b1;
          state    <= FB_WR;
        end
        FB_WR: begin
          if ((fb_rd_data & mask) != 8'h00) collision <= 1'b1;
          if (!(last_sx && last_sy)) begin
            sx      <= nsx;
            sy      <= nsy;
            fb_addr <= idxn[IW-1:3];
            mask    <= 8'h80 >> idxn[2:0];
            state   <= FB_RD;
          end else if (!last_col) begin
            col   <= col + 3'd1;
            state <= PIX;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // End of a sprite row: move to the next row or finish the draw.
      if (row_end) begin
        row <= row + 4'd1;
        col <= '0;
        if (last_row) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state       <= FETCH;
          mem_rd_addr <= base + 12'(row) + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: clip and wrap instances share stimulus; a pixel-level
// framebuffer model predicts every write, the final image, latency and collision.
module tb_sprite_blitter;
  localparam int W = 64;
  localparam int H = 32;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in, start;
  logic [7:0]  x_in, y_in;
  logic [3:0]  n_in;
  logic [11:0] spr_addr;

  logic [11:0] mem_rd_addr_a, mem_rd_addr_b;
  logic [7:0]  mem_rd_data_a, mem_rd_data_b;
  logic [9:0]  fb_addr_a, fb_addr_b;
  logic [7:0]  fb_rd_data_a, fb_rd_data_b, fb_wr_data_a, fb_wr_data_b;
  logic        fb_wr_en_a, fb_wr_en_b, busy_a, busy_b, done_a, done_b, coll_a, coll_b;

  sprite_blitter #(.DISP_W(W), .DISP_H(H), .SCALE(S), .WRAP_MODE(0)) u_dut (
    .clk_in(clk), .rst_in(rst_in), .start(start), .x_in(x_in), .y_in(y_in), .n_in(n_in),
    .spr_addr(spr_addr), .mem_rd_addr(mem_rd_addr_a), .mem_rd_data(mem_rd_data_a),
    .fb_addr(fb_addr_a), .fb_rd_data(fb_rd_data_a), .fb_wr_data(fb_wr_data_a),
    .fb_wr_en(fb_wr_en_a), .busy(busy_a), .done(done_a), .collision(coll_a));

  sprite_blitter #(.DISP_W(W), .DISP_H(H), .SCALE(S), .WRAP_MODE(1)) u_wrap (
    .clk_in(clk), .rst_in(rst_in), .start(start), .x_in(x_in), .y_in(y_in), .n_in(n_in),
    .spr_addr(spr_addr), .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(mem_rd_data_b),
    .fb_addr(fb_addr_b), .fb_rd_data(fb_rd_data_b), .fb_wr_data(fb_wr_data_b),
    .fb_wr_en(fb_wr_en_b), .busy(busy_b), .done(done_b), .collision(coll_b));

  logic [7:0] prog [4096];
  logic [7:0] fb_a [1024];
  logic [7:0] fb_b [1024];
  logic [7:0] mfb  [2][1024];
  logic       clr = 1'b0;

  always @(posedge clk) begin
    mem_rd_data_a <= prog[mem_rd_addr_a];
    mem_rd_data_b <= prog[mem_rd_addr_b];
    fb_rd_data_a  <= fb_a[fb_addr_a];
    fb_rd_data_b  <= fb_b[fb_addr_b];
    if (clr) begin
      for (int i = 0; i < 1024; i++) begin
        fb_a[i] <= 8'h00;
        fb_b[i] <= 8'h00;
      end
    end else begin
      if (fb_wr_en_a) fb_a[fb_addr_a] <= fb_wr_data_a;
      if (fb_wr_en_b) fb_b[fb_addr_b] <= fb_wr_data_b;
    end
  end

  typedef struct {logic [9:0] addr; logic [7:0] data;} wr_t;
  wr_t exp_q[$];

  int checks = 0, failures = 0;
  int busy_cnt_a = 0, busy_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;

  // Per-cycle compare of the clip instance's write stream against the model.
  always @(negedge clk) begin
    if (busy_a) busy_cnt_a++;
    if (busy_b) busy_cnt_b++;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (fb_wr_en_a) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL fb_write unexpected: actual addr=%0d data=%02h, required no write",
                 fb_addr_a, fb_wr_data_a);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (fb_addr_a !== e.addr || fb_wr_data_a !== e.data) begin
          failures++;
          $display("FAIL fb_write: actual addr=%0d data=%02h, required addr=%0d data=%02h",
                   fb_addr_a, fb_wr_data_a, e.addr, e.data);
        end
      end
    end
    if (busy_a && done_a) begin
      checks++;
      failures++;
      $display("FAIL busy_done_overlap: actual busy=1 done=1, required not both");
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pixel-level model: XOR each replicated sub-pixel into the model image.
  task automatic model(input logic [7:0] x, y, input logic [3:0] n, input logic [11:0] a,
                       input int w, output int drawn, output bit coll);
    int x0, y0, px, py, idx, byt, bp;
    logic [7:0] b;
    bit vis;
    drawn = 0;
    coll  = 0;
    x0 = int'(x) % W;
    y0 = int'(y) % H;
    for (int r = 0; r < int'(n); r++) begin
      b = prog[12'(int'(a) + r)];
      for (int c = 0; c < 8; c++) begin
        if (b[7-c]) begin
          px = x0 + c;
          py = y0 + r;
          vis = 1;
          if (px >= W) begin if (w == 1) px -= W; else vis = 0; end
          if (py >= H) begin if (w == 1) py -= H; else vis = 0; end
          if (vis) begin
            drawn++;
            for (int sy = 0; sy < S; sy++)
              for (int sx = 0; sx < S; sx++) begin
                idx = (py * S + sy) * (W * S) + px * S + sx;
                byt = idx / 8;
                bp  = 7 - (idx % 8);
                if (mfb[w][byt][bp]) coll = 1;
                mfb[w][byt][bp] = ~mfb[w][byt][bp];
                if (w == 0) exp_q.push_back('{addr: 10'(byt), data: mfb[0][byt]});
              end
          end
        end
      end
    end
  endtask

  task automatic clear_fb();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mfb[0][i] = 8'h00;
      mfb[1][i] = 8'h00;
    end
  endtask

  task automatic draw(input logic [7:0] x, y, input logic [3:0] n, input logic [11:0] a,
                      input bit mid_start);
    int d0, d1, errs_a, errs_b;
    bit c0, c1;
    model(x, y, n, a, 0, d0, c0);
    model(x, y, n, a, 1, d1, c1);
    @(posedge clk); #1;
    busy_cnt_a = 0; busy_cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
    x_in = x; y_in = y; n_in = n; spr_addr = a;
    start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = mid_start && (i == 6);
      if (done_cnt_a > 0 && done_cnt_b > 0) break;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_cycles", busy_cnt_a, 10 * int'(n) + 2 * S * S * d0);
    check("busy_cycles_wrap", busy_cnt_b, 10 * int'(n) + 2 * S * S * d1);
    check("done_pulses", done_cnt_a, 1);
    check("done_pulses_wrap", done_cnt_b, 1);
    check("collision", int'(coll_a), int'(c0));
    check("collision_wrap", int'(coll_b), int'(c1));
    check("pending_writes", exp_q.size(), 0);
    errs_a = 0;
    errs_b = 0;
    for (int i = 0; i < 1024; i++) begin
      if (fb_a[i] !== mfb[0][i]) errs_a++;
      if (fb_b[i] !== mfb[1][i]) errs_b++;
    end
    check("fb_image_bad_bytes", errs_a, 0);
    check("fb_image_wrap_bad_bytes", errs_b, 0);
  endtask

  initial begin
    int d;
    bit c;
    for (int i = 0; i < 4096; i++) prog[i] = 8'h00;
    rst_in = 1'b1; start = 1'b1; x_in = 8'd0; y_in = 8'd0; n_in = 4'd1; spr_addr = 12'h000;

    // Reset held two cycles with start asserted.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_collision", int'(coll_a), 0);
      check("rst_fb_wr_en", int'(fb_wr_en_a), 0);
      check("rst_mem_rd_addr", int'(mem_rd_addr_a), 0);
      check("rst_fb_addr", int'(fb_addr_a), 0);
      check("rst_fb_wr_data", int'(fb_wr_data_a), 0);
    end
    start = 1'b0;
    rst_in = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", int'(busy_a), 0);

    clear_fb();
    prog[12'h200] = 8'h80;
    draw(8'd0, 8'd0, 4'd1, 12'h200, 0);
    check("single_byte0", int'(fb_a[0]), 8'hC0);
    check("single_byte16", int'(fb_a[16]), 8'hC0);
    check("single_busy_lit", busy_cnt_a, 18);
    check("single_coll_lit", int'(coll_a), 0);

    draw(8'd0, 8'd0, 4'd1, 12'h200, 0);
    check("erase_byte0", int'(fb_a[0]), 8'h00);
    check("erase_byte16", int'(fb_a[16]), 8'h00);
    check("erase_coll_lit", int'(coll_a), 1);

    draw(8'd5, 8'd5, 4'd0, 12'h200, 0);
    check("n0_coll_lit", int'(coll_a), 0);
    check("n0_busy_lit", busy_cnt_a, 0);

    clear_fb();
    prog[12'h210] = 8'hC0;
    draw(8'd63, 8'd0, 4'd1, 12'h210, 0);
    check("clip_byte15", int'(fb_a[15]), 8'h03);
    check("clip_byte31", int'(fb_a[31]), 8'h03);
    check("clip_byte0", int'(fb_a[0]), 8'h00);
    check("wrap_byte15", int'(fb_b[15]), 8'h03);
    check("wrap_byte0", int'(fb_b[0]), 8'hC0);
    check("wrap_byte16", int'(fb_b[16]), 8'hC0);
    check("wrap_busy_lit", busy_cnt_b, 26);

    clear_fb();
    draw(8'd70, 8'd33, 4'd1, 12'h200, 1);
    check("mod_byte33", int'(fb_a[33]), 8'h0C);
    check("mod_byte49", int'(fb_a[49]), 8'h0C);

    prog[12'h300] = 8'hA5; prog[12'h301] = 8'h3C; prog[12'h302] = 8'hFF;
    draw(8'd60, 8'd30, 4'd3, 12'h300, 0);
    draw(8'd61, 8'd31, 4'd3, 12'h300, 0);
    draw(8'd10, 8'd5, 4'd3, 12'h300, 0);
    prog[12'hFFF] = 8'h81; prog[12'h000] = 8'h18;
    draw(8'd20, 8'd10, 4'd2, 12'hFFF, 0);

    // Reset during FB_RD of the second drawn pixel.
    clear_fb();
    prog[12'h220] = 8'hC0;
    model(8'd0, 8'd0, 4'd1, 12'h220, 0, d, c);
    @(posedge clk); #1;
    x_in = 8'd0; y_in = 8'd0; n_in = 4'd1; spr_addr = 12'h220; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst_in = 1'b1;
    check("abort_writes_left", exp_q.size(), 4);
    exp_q.delete();
    @(posedge clk); #1 rst_in = 1'b0;
    check("abort_busy", int'(busy_a), 0);
    check("abort_fb_wr_en", int'(fb_wr_en_a), 0);
    check("abort_fb_addr", int'(fb_addr_a), 0);
    check("abort_mem_rd_addr", int'(mem_rd_addr_a), 0);
    check("abort_collision", int'(coll_a), 0);
    repeat (30) @(posedge clk);
    #1;
    check("abort_busy_later", int'(busy_a), 0);
    check("abort_byte0", int'(fb_a[0]), 8'hC0);
    check("abort_byte16", int'(fb_a[16]), 8'hC0);

    clear_fb();
    draw(8'd0, 8'd0, 4'd1, 12'h220, 0);
    check("after_abort_byte0", int'(fb_a[0]), 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
